vec_cache_sram_bank: RTL and testbench

VEC_CACHE_SRAM_BANK -- requirements
Module: vec_cache_sram_bank

---
 rtl/vec_cache_sram_bank_if.sv | 29 ++
 rtl/vec_cache_sram_bank.sv | 144 ++++++++++++++
 tb/tb_vec_cache_sram_bank.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cache_sram_bank_if.sv
// vec_cache_sram_bank_if: write port and read request/response bundle of the vector SRAM bank
interface vec_cache_sram_bank_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int LANE_NUM = 4
) ();
  localparam int DATA_W = 8 * LANE_NUM;
  localparam int SEL_W = $clog2(LANE_NUM);
  logic wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SEL_W-1:0] wr_sel;
  logic wr_mode;
  logic [DATA_W-1:0] wr_data;
  logic rd_req_vld;
  logic rd_req_rdy;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [SEL_W-1:0] rd_sel;
  logic rd_mode;
  logic rd_resp_vld;
  logic [DATA_W-1:0] rd_resp_data;
  logic rd_par_err;
  modport master (
    output wr_vld, wr_addr, wr_sel, wr_mode, wr_data, rd_req_vld, rd_addr, rd_sel, rd_mode,
    input rd_req_rdy, rd_resp_vld, rd_resp_data, rd_par_err
  );
  modport slave (
    input wr_vld, wr_addr, wr_sel, wr_mode, wr_data, rd_req_vld, rd_addr, rd_sel, rd_mode,
    output rd_req_rdy, rd_resp_vld, rd_resp_data, rd_par_err
  );
endinterface

// File: rtl/vec_cache_sram_bank.sv
// vec_cache_sram_bank: byte-enabled line SRAM with lane / strided-byte access and a one-entry read stall buffer.
// Define VEC_SRAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on rd_par_err.
module vec_cache_sram_bank #(
  parameter int ADDR_WIDTH = 9,
  parameter int LANE_NUM = 4,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  vec_cache_sram_bank_if.slave bus
);
  localparam int DATA_W = 8 * LANE_NUM;
  localparam int NB = LANE_NUM * LANE_NUM;
  localparam int LINE_W = 8 * NB;
  localparam int SEL_W = $clog2(LANE_NUM);
  localparam int BI_W = 2 * SEL_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // With LANE_NUM a power of two, j*LANE_NUM+k and k*LANE_NUM+j are plain concatenations
  function automatic logic [BI_W-1:0] byte_idx(input logic mode, input logic [SEL_W-1:0] sel,
                                               input logic [SEL_W-1:0] j);
    return mode ? {j, sel} : {sel, j};
  endfunction

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] wr_line;
  logic [NB-1:0] wr_be;
  logic [LINE_W-1:0] line_q;
  logic pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic pend_mode_q, pend_mode_d;
  logic acc, issue;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic s1_vld_q, s1_vld_d;
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;
  logic s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0] resp_data;
  logic resp_err;
  logic [BI_W-1:0] rbi;

  always_comb begin
    wr_line = '0;
    wr_be = '0;
    for (int j = 0; j < LANE_NUM; j++) begin
      wr_be[byte_idx(bus.wr_mode, bus.wr_sel, SEL_W'(j))] = 1'b1;
      wr_line[{byte_idx(bus.wr_mode, bus.wr_sel, SEL_W'(j)), 3'b000} +: 8] = bus.wr_data[j*8 +: 8];
    end
  end

  // Writes own the single array port; an accepted read waits in the pending slot while wr_vld is high
  always_comb begin
    acc = bus.rd_req_vld & !pend_vld_q;
    issue = (pend_vld_q | acc) & !bus.wr_vld;
    iss_addr = pend_vld_q ? pend_addr_q : bus.rd_addr;
    s1_vld_d = issue;
    s1_sel_d = pend_vld_q ? pend_sel_q : bus.rd_sel;
    s1_mode_d = pend_vld_q ? pend_mode_q : bus.rd_mode;
    pend_vld_d = pend_vld_q ? bus.wr_vld : acc & bus.wr_vld;
    pend_addr_d = acc ? bus.rd_addr : pend_addr_q;
    pend_sel_d = acc ? bus.rd_sel : pend_sel_q;
    pend_mode_d = acc ? bus.rd_mode : pend_mode_q;
  end

  assign bus.rd_req_rdy = !pend_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_addr_q <= '0;
      pend_sel_q <= '0;
      pend_mode_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_sel_q <= '0;
      s1_mode_q <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_sel_q <= pend_sel_d;
      pend_mode_q <= pend_mode_d;
      s1_vld_q <= s1_vld_d;
      s1_sel_q <= s1_sel_d;
      s1_mode_q <= s1_mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_vld)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem[bus.wr_addr][b*8 +: 8] <= wr_line[b*8 +: 8];
    if (issue) line_q <= mem[iss_addr];
  end

`ifdef VEC_SRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_q;

  always_ff @(posedge clk) begin
    if (bus.wr_vld)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) par_mem[bus.wr_addr][b] <= ^wr_line[b*8 +: 8];
    if (issue) par_q <= par_mem[iss_addr];
  end
`endif

  always_comb begin
    resp_data = '0;
    resp_err = 1'b0;
    rbi = '0;
    for (int j = 0; j < LANE_NUM; j++) begin
      rbi = byte_idx(s1_mode_q, s1_sel_q, SEL_W'(j));
      resp_data[j*8 +: 8] = line_q[{rbi, 3'b000} +: 8];
`ifdef VEC_SRAM_PARITY_EN
      resp_err = resp_err | ((^line_q[{rbi, 3'b000} +: 8]) != par_q[rbi]);
`endif
    end
    resp_data = resp_data & {DATA_W{s1_vld_q}};
    resp_err = resp_err & s1_vld_q;
  end

  if (RD_LAT == 2) begin : g_out
    logic o_vld_q;
    logic [DATA_W-1:0] o_data_q;
    logic o_err_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        o_vld_q <= 1'b0;
        o_data_q <= '0;
        o_err_q <= 1'b0;
      end else begin
        o_vld_q <= s1_vld_q;
        o_data_q <= resp_data;
        o_err_q <= resp_err;
      end
    end
    assign bus.rd_resp_vld = o_vld_q;
    assign bus.rd_resp_data = o_data_q;
    assign bus.rd_par_err = o_err_q;
  end else begin : g_dir
    assign bus.rd_resp_vld = s1_vld_q;
    assign bus.rd_resp_data = resp_data;
    assign bus.rd_par_err = resp_err;
  end
endmodule

// File: tb/tb_vec_cache_sram_bank.sv
// tb_vec_cache_sram_bank: directed vectors for lane/strided access, write stalls and reset of the SRAM bank
module tb_vec_cache_sram_bank;
  localparam int RD_LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  vec_cache_sram_bank_if #(.ADDR_WIDTH(9), .LANE_NUM(4)) bus ();
  vec_cache_sram_bank #(.ADDR_WIDTH(9), .LANE_NUM(4), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic wr(input logic [8:0] a, input logic m, input logic [1:0] s, input logic [31:0] d);
    bus.wr_vld = 1'b1;
    bus.wr_addr = a;
    bus.wr_mode = m;
    bus.wr_sel = s;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_vld = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, input logic m, input logic [1:0] s,
                         output int lat, output logic [31:0] d, output logic pe);
    bus.rd_req_vld = 1'b1;
    bus.rd_addr = a;
    bus.rd_mode = m;
    bus.rd_sel = s;
    @(negedge clk);
    bus.rd_req_vld = 1'b0;
    lat = 1;
    while (bus.rd_resp_vld !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = bus.rd_resp_data;
    pe = bus.rd_par_err;
  endtask

  task automatic test_reset;
    bus.wr_vld = 1'b0; bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_mode = 1'b0; bus.wr_data = '0;
    bus.rd_req_vld = 1'b0; bus.rd_addr = '0; bus.rd_sel = '0; bus.rd_mode = 1'b0;
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.rd_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", bus.rd_req_rdy); end
    if (bus.rd_resp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.rd_resp_vld); end
    if (bus.rd_resp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.rd_resp_data); end
    if (bus.rd_par_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.rd_par_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr(9'd5, 1'b0, 2'(k), 32'h0);
      wr(9'd3, 1'b0, 2'(k), 32'hA0A0A0A0 + k * 32'h01010101);
      wr(9'd7, 1'b0, 2'(k), 32'h0);
      wr(9'd9, 1'b0, 2'(k), 32'h0);
    end
  endtask

  task automatic test_lane;
    int lat;
    logic [31:0] d;
    logic pe;
    wr(9'd5, 1'b0, 2'd2, 32'hA1B2C3D4);
    do_read(9'd5, 1'b0, 2'd2, lat, d, pe);
    checks += 3;
    if (lat !== RD_LAT) begin errors++; $display("FAIL lane_lat: got %0d expected %0d", lat, RD_LAT); end
    if (d !== 32'hA1B2C3D4) begin errors++; $display("FAIL lane_sel2: got %h expected a1b2c3d4", d); end
    if (pe !== 1'b0) begin errors++; $display("FAIL lane_perr: got %b expected 0", pe); end
    do_read(9'd5, 1'b0, 2'd0, lat, d, pe);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL lane_sel0: got %h expected 00000000", d); end
    do_read(9'd5, 1'b1, 2'd0, lat, d, pe);
    checks++;
    if (d !== 32'h00D40000) begin errors++; $display("FAIL lane_stride_view: got %h expected 00d40000", d); end
  endtask

  task automatic test_strided;
    int lat;
    logic [31:0] d;
    logic pe;
    logic [31:0] exp_l [4];
    exp_l = '{32'hA0A011A0, 32'hA1A122A1, 32'hA2A233A2, 32'hA3A344A3};
    wr(9'd3, 1'b1, 2'd1, 32'h44332211);
    for (int k = 0; k < 4; k++) begin
      do_read(9'd3, 1'b0, 2'(k), lat, d, pe);
      checks++;
      if (d !== exp_l[k]) begin errors++; $display("FAIL stride_lane%0d: got %h expected %h", k, d, exp_l[k]); end
    end
    do_read(9'd3, 1'b1, 2'd1, lat, d, pe);
    checks++;
    if (d !== 32'h44332211) begin errors++; $display("FAIL stride_sel1: got %h expected 44332211", d); end
    do_read(9'd3, 1'b1, 2'd0, lat, d, pe);
    checks++;
    if (d !== 32'hA3A2A1A0) begin errors++; $display("FAIL stride_sel0: got %h expected a3a2a1a0", d); end
  endtask

  task automatic test_collision;
    int lat;
    bus.rd_req_vld = 1'b1; bus.rd_addr = 9'd5; bus.rd_mode = 1'b0; bus.rd_sel = 2'd2;
    bus.wr_vld = 1'b1; bus.wr_addr = 9'd11; bus.wr_mode = 1'b0; bus.wr_sel = 2'd0; bus.wr_data = 32'h55;
    @(negedge clk);
    bus.rd_req_vld = 1'b0;
    bus.wr_vld = 1'b0;
    checks++;
    if (bus.rd_req_rdy !== 1'b0) begin errors++; $display("FAIL coll_rdy_low: got %b expected 0", bus.rd_req_rdy); end
    lat = 0;
    while (bus.rd_resp_vld !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks += 3;
    if (lat !== RD_LAT) begin errors++; $display("FAIL coll_lat: got %0d expected %0d", lat, RD_LAT); end
    if (bus.rd_resp_data !== 32'hA1B2C3D4) begin errors++; $display("FAIL coll_data: got %h expected a1b2c3d4", bus.rd_resp_data); end
    if (bus.rd_req_rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy_back: got %b expected 1", bus.rd_req_rdy); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    int lat;
    bus.rd_req_vld = 1'b1; bus.rd_addr = 9'd7; bus.rd_mode = 1'b0; bus.rd_sel = 2'd0;
    bus.wr_vld = 1'b1; bus.wr_addr = 9'd7; bus.wr_mode = 1'b0; bus.wr_sel = 2'd0; bus.wr_data = 32'h12345678;
    @(negedge clk);
    bus.rd_req_vld = 1'b0;
    bus.wr_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (bus.rd_req_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy%0d: got %b expected 0", i, bus.rd_req_rdy); end
      if (bus.rd_resp_vld !== 1'b0) begin errors++; $display("FAIL stall_vld%0d: got %b expected 0", i, bus.rd_resp_vld); end
      @(negedge clk);
    end
    bus.wr_vld = 1'b0;
    lat = 0;
    while (bus.rd_resp_vld !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks += 2;
    if (lat !== RD_LAT) begin errors++; $display("FAIL stall_lat: got %0d expected %0d", lat, RD_LAT); end
    if (bus.rd_resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_data: got %h expected deadbeef", bus.rd_resp_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_l [3];
    int k;
    exp_l = '{32'hA0A011A0, 32'hA1A122A1, 32'hA2A233A2};
    for (int c = 0; c < 3 + RD_LAT; c++) begin
      bus.rd_req_vld = (c < 3);
      bus.rd_addr = 9'd3;
      bus.rd_mode = 1'b0;
      bus.rd_sel = 2'(c);
      @(negedge clk);
      k = c + 1 - RD_LAT;
      checks++;
      if (k >= 0 && k < 3) begin
        if (bus.rd_resp_vld !== 1'b1 || bus.rd_resp_data !== exp_l[k]) begin
          errors++;
          $display("FAIL b2b_resp%0d: got vld=%b data=%h expected vld=1 data=%h", k, bus.rd_resp_vld, bus.rd_resp_data, exp_l[k]);
        end
      end else if (bus.rd_resp_vld !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle%0d: got vld=%b expected 0", c, bus.rd_resp_vld);
      end
    end
    bus.rd_req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rd_resp_vld !== 1'b0) begin errors++; $display("FAIL b2b_tail: got vld=%b expected 0", bus.rd_resp_vld); end
  endtask

  task automatic test_reset_inflight;
    bus.rd_req_vld = 1'b1; bus.rd_addr = 9'd5; bus.rd_mode = 1'b0; bus.rd_sel = 2'd2;
    @(negedge clk);
    bus.rd_addr = 9'd3; bus.rd_sel = 2'd0;
    bus.wr_vld = 1'b1; bus.wr_addr = 9'd12; bus.wr_mode = 1'b0; bus.wr_sel = 2'd0; bus.wr_data = 32'h1;
    @(negedge clk);
    bus.rd_req_vld = 1'b0;
    checks++;
    if (bus.rd_req_rdy !== 1'b0) begin errors++; $display("FAIL rst_pend_before: got %b expected 0", bus.rd_req_rdy); end
    rst = 1'b1;
    #1;
    bus.wr_vld = 1'b0;
    checks += 3;
    if (bus.rd_req_rdy !== 1'b1) begin errors++; $display("FAIL rst_async_rdy: got %b expected 1", bus.rd_req_rdy); end
    if (bus.rd_resp_vld !== 1'b0) begin errors++; $display("FAIL rst_async_vld: got %b expected 0", bus.rd_resp_vld); end
    if (bus.rd_resp_data !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h expected 0", bus.rd_resp_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (bus.rd_resp_vld !== 1'b0) begin errors++; $display("FAIL rst_post_vld%0d: got %b expected 0", i, bus.rd_resp_vld); end
      if (bus.rd_req_rdy !== 1'b1) begin errors++; $display("FAIL rst_post_rdy%0d: got %b expected 1", i, bus.rd_req_rdy); end
    end
  endtask

  task automatic test_parity;
    int lat;
    logic [31:0] d;
    logic pe;
`ifdef VEC_SRAM_PARITY_EN
    wr(9'd9, 1'b0, 2'd0, 32'h01020304);
    do_read(9'd9, 1'b0, 2'd0, lat, d, pe);
    checks += 2;
    if (d !== 32'h01020304) begin errors++; $display("FAIL par_clean_data: got %h expected 01020304", d); end
    if (pe !== 1'b0) begin errors++; $display("FAIL par_clean: got %b expected 0", pe); end
    dut.mem[9][3] = ~dut.mem[9][3];
    do_read(9'd9, 1'b0, 2'd0, lat, d, pe);
    checks += 2;
    if (lat !== RD_LAT) begin errors++; $display("FAIL par_err_lat: got %0d expected %0d", lat, RD_LAT); end
    if (pe !== 1'b1) begin errors++; $display("FAIL par_err: got %b expected 1", pe); end
    do_read(9'd9, 1'b0, 2'd1, lat, d, pe);
    checks++;
    if (pe !== 1'b0) begin errors++; $display("FAIL par_other_lane: got %b expected 0", pe); end
`else
    do_read(9'd9, 1'b0, 2'd0, lat, d, pe);
    checks += 2;
    if (d !== 32'h0) begin errors++; $display("FAIL nopar_data: got %h expected 0", d); end
    if (pe !== 1'b0) begin errors++; $display("FAIL nopar_perr: got %b expected 0", pe); end
`endif
  endtask

  initial begin
    test_reset;
    test_lane;
    test_strided;
    test_collision;
    test_stall;
    test_back_to_back;
    test_reset_inflight;
    test_parity;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
